param_cmd_ram: RTL and testbench

PARAM_CMD_RAM -- requirements
Module: param_cmd_ram

---
 rtl/param_cmd_ram.sv | 130 +++++++++++++
 tb/tb_param_cmd_ram.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/param_cmd_ram.sv
// Command-driven RAM: 2-bit opcode selects set-write-addr / write-data / set-read-addr / read-data.
// Latency 1 cycle from read command to registered dout; no backpressure, one command per cycle.
module param_cmd_ram #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              err
);

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  typedef enum logic {
    ST_NONE  = 1'b0,
    ST_READY = 1'b1
  } ok_st_t;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(MEM_DEPTH - 1);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  cmd_t              cmd;
  logic [DATA_W-1:0] payload;
  logic [ADDR_W-1:0] addr_in;
  logic              addr_oob;

  ok_st_t            wr_st, wr_st_nxt;
  ok_st_t            rd_st, rd_st_nxt;
  logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
  logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
  logic              mem_we;
  logic              rd_en;
  logic              err_nxt;

  assign cmd      = cmd_t'(din[DATA_W+1:DATA_W]);
  assign payload  = din[DATA_W-1:0];
  assign addr_in  = payload[ADDR_W-1:0];
  assign addr_oob = {1'b0, addr_in} >= DEPTH_L;

  // Post-increment wraps at the configured depth, not at the address-field width.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST_A) ? '0 : a + 1'b1;
  endfunction

  always_comb begin
    wr_st_nxt   = wr_st;
    rd_st_nxt   = rd_st;
    wr_addr_nxt = wr_addr;
    rd_addr_nxt = rd_addr;
    mem_we      = 1'b0;
    rd_en       = 1'b0;
    err_nxt     = 1'b0;
    if (rx_valid) begin
      unique case (cmd)
        CMD_WR_ADDR: begin
          if (addr_oob) begin
            err_nxt = 1'b1;
          end else begin
            wr_addr_nxt = addr_in;
            wr_st_nxt   = ST_READY;
          end
        end
        CMD_WR_DATA: begin
          if (wr_st == ST_READY) begin
            mem_we = 1'b1;
            if (AUTO_INC != 0) wr_addr_nxt = addr_inc(wr_addr);
          end else begin
            err_nxt = 1'b1;
          end
        end
        CMD_RD_ADDR: begin
          if (addr_oob) begin
            err_nxt = 1'b1;
          end else begin
            rd_addr_nxt = addr_in;
            rd_st_nxt   = ST_READY;
          end
        end
        CMD_RD_DATA: begin
          if (rd_st == ST_READY) begin
            rd_en = 1'b1;
            if (AUTO_INC != 0) rd_addr_nxt = addr_inc(rd_addr);
          end else begin
            err_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_st    <= ST_NONE;
      rd_st    <= ST_NONE;
      wr_addr  <= '0;
      rd_addr  <= '0;
      dout     <= '0;
      tx_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      wr_st    <= wr_st_nxt;
      rd_st    <= rd_st_nxt;
      wr_addr  <= wr_addr_nxt;
      rd_addr  <= rd_addr_nxt;
      tx_valid <= rd_en;
      err      <= err_nxt;
      if (rd_en) dout <= mem[rd_addr];
    end
  end

  // Storage has no reset so contents persist across rst_n pulses.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= payload;
  end

endmodule

// File: tb/tb_param_cmd_ram.sv
module tb_param_cmd_ram;

  logic       clk;
  logic       rst_n;
  logic [9:0] din;
  logic [2:0] rxv;

  logic [7:0] dout0, dout1, dout2;
  logic       tx0, tx1, tx2;
  logic       er0, er1, er2;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         sel;
    logic       tx;
    logic       er;
    logic [7:0] dv;
    string      tag;
  } exp_t;

  exp_t sb[$];

  param_cmd_ram u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rxv[0]),
    .dout(dout0), .tx_valid(tx0), .err(er0)
  );

  param_cmd_ram #(.AUTO_INC(1)) u_inc (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rxv[1]),
    .dout(dout1), .tx_valid(tx1), .err(er1)
  );

  param_cmd_ram #(.MEM_DEPTH(200)) u_d200 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rxv[2]),
    .dout(dout2), .tx_valid(tx2), .err(er2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_cycle();
    exp_t       e;
    logic       t;
    logic       r;
    logic [7:0] d;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       begin t = tx0; r = er0; d = dout0; end
        1:       begin t = tx1; r = er1; d = dout1; end
        default: begin t = tx2; r = er2; d = dout2; end
      endcase
      chk({e.tag, "/tx_valid"}, 32'(t), 32'(e.tx));
      chk({e.tag, "/err"}, 32'(r), 32'(e.er));
      chk({e.tag, "/dout"}, 32'(d), 32'(e.dv));
      chk({e.tag, "/tx_and_err"}, 32'(t & r), 32'd0);
    end
  endtask

  task automatic send(input int sel, input logic [1:0] c, input logic [7:0] p, input string tag,
                      input logic etx, input logic eer, input logic [7:0] ed);
    exp_t e;
    @(negedge clk);
    din      = {c, p};
    rxv      = 3'b000;
    rxv[sel] = 1'b1;
    e = '{sel, etx, eer, ed, tag};
    sb.push_back(e);
    @(posedge clk);
    #1;
    rxv = 3'b000;
    check_cycle();
  endtask

  task automatic idle(input int sel, input logic [7:0] ed, input string tag);
    exp_t e;
    @(negedge clk);
    rxv = 3'b000;
    e = '{sel, 1'b0, 1'b0, ed, tag};
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  task automatic chk_rst_outs(input string tag);
    chk({tag, "/dout0"}, 32'(dout0), 32'd0);
    chk({tag, "/tx0"},   32'(tx0),   32'd0);
    chk({tag, "/err0"},  32'(er0),   32'd0);
    chk({tag, "/dout1"}, 32'(dout1), 32'd0);
    chk({tag, "/dout2"}, 32'(dout2), 32'd0);
  endtask

  task automatic pulse_rst(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_rst_outs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 5) & 8'hFF);
  endfunction

  initial begin
    rst_n = 1'b0;
    din   = '0;
    rxv   = 3'b000;
    #12;
    chk_rst_outs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Seed addr 0, then reset: commands without an address must be rejected.
    send(0, 2'b00, 8'h00, "seed_wa", 0, 0, 8'h00);
    send(0, 2'b01, 8'h5A, "seed_wd", 0, 0, 8'h00);
    pulse_rst("rst1");
    send(0, 2'b01, 8'h33, "wd_noaddr", 0, 1, 8'h00);
    send(0, 2'b11, 8'h00, "rd_noaddr", 0, 1, 8'h00);

    send(0, 2'b00, 8'h12, "wa_12", 0, 0, 8'h00);
    send(0, 2'b01, 8'hA5, "wd_a5", 0, 0, 8'h00);
    send(0, 2'b10, 8'h12, "ra_12", 0, 0, 8'h00);
    send(0, 2'b11, 8'h00, "rd_a5", 1, 0, 8'hA5);
    idle(0, 8'hA5, "hold_a5");
    idle(0, 8'hA5, "hold_a5_2");

    send(0, 2'b10, 8'h00, "ra_00", 0, 0, 8'hA5);
    send(0, 2'b11, 8'h00, "rd_mem0", 1, 0, 8'h5A);

    send(0, 2'b00, 8'h40, "wa_40", 0, 0, 8'h5A);
    send(0, 2'b10, 8'h40, "ra_40", 0, 0, 8'h5A);
    send(0, 2'b01, 8'h9C, "wd_9c", 0, 0, 8'h5A);
    send(0, 2'b11, 8'hFF, "raw_9c", 1, 0, 8'h9C);
    send(0, 2'b11, 8'h00, "raw_9c_b2b", 1, 0, 8'h9C);

    for (int i = 0; i < 8; i++) begin
      send(0, 2'b00, 8'(8'h80 + i), "pat_wa", 0, 0, 8'h9C);
      send(0, 2'b01, pat(i), "pat_wd", 0, 0, 8'h9C);
    end
    begin
      logic [7:0] last;
      last = 8'h9C;
      for (int i = 7; i >= 0; i--) begin
        send(0, 2'b10, 8'(8'h80 + i), "pat_ra", 0, 0, last);
        send(0, 2'b11, 8'h00, "pat_rd", 1, 0, pat(i));
        last = pat(i);
      end
    end

    send(0, 2'b00, 8'h03, "wa_03", 0, 0, pat(0));
    send(0, 2'b01, 8'h7E, "wd_7e", 0, 0, pat(0));
    pulse_rst("rst2");
    send(0, 2'b10, 8'h03, "ra_03", 0, 0, 8'h00);
    send(0, 2'b11, 8'h00, "rd_7e_kept", 1, 0, 8'h7E);

    send(0, 2'b00, 8'h05, "wa_05", 0, 0, 8'h7E);
    send(0, 2'b01, 8'h66, "wd_66", 0, 0, 8'h7E);
    send(0, 2'b10, 8'h05, "ra_05", 0, 0, 8'h7E);
    send(0, 2'b11, 8'h00, "rd_66", 1, 0, 8'h66);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst/dout", 32'(dout0), 32'd0);
    chk("midrst/tx",   32'(tx0),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 2'b11, 8'h00, "rd_after_rst", 0, 1, 8'h00);

    send(1, 2'b00, 8'hFF, "inc_wa_ff", 0, 0, 8'h00);
    send(1, 2'b01, 8'h11, "inc_wd_11", 0, 0, 8'h00);
    send(1, 2'b01, 8'h22, "inc_wd_22", 0, 0, 8'h00);
    send(1, 2'b10, 8'hFF, "inc_ra_ff", 0, 0, 8'h00);
    send(1, 2'b11, 8'h00, "inc_rd_ff", 1, 0, 8'h11);
    send(1, 2'b11, 8'h00, "inc_rd_wrap", 1, 0, 8'h22);
    idle(1, 8'h22, "inc_idle");

    send(2, 2'b00, 8'hC8, "oob_wa", 0, 1, 8'h00);
    send(2, 2'b01, 8'h55, "oob_wd", 0, 1, 8'h00);
    send(2, 2'b00, 8'hC7, "last_wa", 0, 0, 8'h00);
    send(2, 2'b01, 8'h55, "last_wd", 0, 0, 8'h00);
    send(2, 2'b10, 8'hC8, "oob_ra", 0, 1, 8'h00);
    send(2, 2'b11, 8'h00, "oob_rd", 0, 1, 8'h00);
    send(2, 2'b10, 8'hC7, "last_ra", 0, 0, 8'h00);
    send(2, 2'b11, 8'h00, "last_rd", 1, 0, 8'h55);
    send(2, 2'b00, 8'hC8, "oob_wa2", 0, 1, 8'h55);
    send(2, 2'b01, 8'h77, "keep_wd", 0, 0, 8'h55);
    send(2, 2'b11, 8'h00, "keep_rd", 1, 0, 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
